// File: rtl/arith_operand_loader_if.sv
// ---------------------------------------------------------------------------
// arith_operand_loader_if
// Purpose : bundles the byte-serial operand stream and the tagged result
//           return channel of the arithmetic operand loader.
// Signals : in_valid/in_ready/in_data/in_first   operand byte stream
//           res_valid/res_ready/res_data/res_tag result stream
// Modports: slave  - the loader (consumes bytes, produces results)
//           master - the producer/consumer environment around the loader
// ---------------------------------------------------------------------------
interface arith_operand_loader_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_first;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [TAG_W-1:0] res_tag;

    modport slave (
        input  in_valid, in_data, in_first, res_ready,
        output in_ready, res_valid, res_data, res_tag
    );

    modport master (
        output in_valid, in_data, in_first, res_ready,
        input  in_ready, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/arith_operand_loader.sv
// ---------------------------------------------------------------------------
// arith_operand_loader
// Purpose : assembles a byte-serial stream into an x1,x2,x3 operand triple,
//           drives it into a combinational arithmetic stage, captures the
//           stage result y after SETTLE cycles and returns it with a
//           wrapping sequence tag.
// Ports   : clk      - single clock, rising edge
//           rst      - asynchronous reset, active high
//           bus      - operand stream in / result stream out (slave modport)
//           x1,x2,x3 - registered operands to the arithmetic stage
//           y        - result from the arithmetic stage
//           drop_err - one-cycle pulse when a partial triple is discarded
//           busy     - high whenever the loader is not waiting for x1
// ---------------------------------------------------------------------------
module arith_operand_loader #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1,
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    arith_operand_loader_if.slave  bus,
    output logic [WIDTH-1:0]       x1,
    output logic [WIDTH-1:0]       x2,
    output logic [WIDTH-1:0]       x3,
    input  logic [WIDTH-1:0]       y,
    output logic                   drop_err,
    output logic                   busy
);

    localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    typedef enum logic [2:0] {
        LD_X1,
        LD_X2,
        LD_X3,
        WAIT,
        RESULT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag_cnt;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic [TAG_W-1:0] res_tag_q;
    logic             accept;

    // Ready is a pure state decode, so the upstream never sees a path from its
    // own valid back into ready.
    assign bus.in_ready = (state == LD_X1) || (state == LD_X2) || (state == LD_X3);
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state != LD_X1);

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_tag   = res_tag_q;

    // NOTE: every register here, including state, uses non-blocking assignment
    // so all updates take effect together at the edge, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LD_X1;
            x1          <= '0;
            x2          <= '0;
            x3          <= '0;
            cnt         <= '0;
            tag_cnt     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            drop_err    <= 1'b0;
        end else begin
            // NOTE: drop_err defaults low every cycle and is only raised by a
            // resync below, which is what makes it a single-cycle pulse.
            drop_err <= 1'b0;
            case (state)
                LD_X1: begin
                    if (accept) begin
                        x1    <= bus.in_data;
                        state <= LD_X2;
                    end
                end
                LD_X2: begin
                    if (accept) begin
                        if (bus.in_first) begin
                            // Resync: this byte starts a new triple.
                            x1       <= bus.in_data;
                            drop_err <= 1'b1;
                        end else begin
                            x2    <= bus.in_data;
                            state <= LD_X3;
                        end
                    end
                end
                LD_X3: begin
                    if (accept) begin
                        if (bus.in_first) begin
                            x1       <= bus.in_data;
                            drop_err <= 1'b1;
                            state    <= LD_X2;
                        end else begin
                            x3    <= bus.in_data;
                            cnt   <= CNT_W'(1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Give the combinational stage SETTLE full cycles with the
                    // complete triple applied before sampling y.
                    if (cnt == SETTLE_C) begin
                        res_data_q  <= y;
                        res_tag_q   <= tag_cnt;
                        res_valid_q <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        tag_cnt     <= tag_cnt + 1'b1;
                        state       <= LD_X1;
                    end
                end
                default: state <= LD_X1;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_arith_operand_loader
// Purpose : self-checking bench for arith_operand_loader wired to a model of
//           the combinational arithmetic stage y = (x1 + x3) * x2 mod 256.
//           Expected results are queued as triples are driven and compared
//           when the loader hands a result over.
// ---------------------------------------------------------------------------
module tb_arith_operand_loader;

    localparam int WIDTH  = 8;
    localparam int TAG_W  = 4;
    localparam int SETTLE = 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] x1, x2, x3, y;
    logic             drop_err, busy;
    logic [15:0]      prod;

    arith_operand_loader_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    arith_operand_loader #(.WIDTH(WIDTH), .SETTLE(SETTLE), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .y        (y),
        .drop_err (drop_err),
        .busy     (busy)
    );

    // Arithmetic stage the loader feeds.
    assign prod = ({8'b0, x1} + {8'b0, x3}) * {8'b0, x2};
    assign y    = prod[7:0];

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   drop_cnt = 0;
    exp_t sb_q[$];
    logic [TAG_W-1:0] exp_tag = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Result monitor: a handshake is visible at the negedge before the edge
    // that completes it.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("res_data", 32'(bus.res_data), 32'(e.data));
                check("res_tag", 32'(bus.res_tag), 32'(e.tag));
            end
        end
        if (!rst && drop_err) drop_cnt <= drop_cnt + 1;
    end

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
        logic [15:0] p;
        p = (16'(a) + 16'(c)) * 16'(b);
        return p[7:0];
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c);
        exp_t e;
        e.data = model(a, b, c);
        e.tag  = exp_tag;
        sb_q.push_back(e);
        exp_tag = exp_tag + 1'b1;
    endtask

    // Offers one byte after 'gap' idle cycles; returns at accept edge + 1.
    task automatic send_byte(input logic [WIDTH-1:0] d, input logic f,
                             input int gap, output int acc);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_first = f;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc          = cyc;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic send_triple(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] c, input int max_gap,
                               input bit expect_res, output int acc1);
        int dummy;
        if (expect_res) push_exp(a, b, c);
        send_byte(a, 1'b1, $urandom_range(0, max_gap), acc1);
        send_byte(b, 1'b0, $urandom_range(0, max_gap), dummy);
        send_byte(c, 1'b0, $urandom_range(0, max_gap), dummy);
    endtask

    task automatic wait_valid(output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("res_valid_timeout", 32'd0, 32'd1);
        at = cyc;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        exp_tag = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc_prev, at, drop_base;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_first  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_x1", 32'(x1), 32'd0);
        check("rst_x2", 32'(x2), 32'd0);
        check("rst_x3", 32'(x3), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_tag", 32'(bus.res_tag), 32'd0);
        check("rst_drop_err", 32'(drop_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 1. Basic triple and latency: result valid in the 5th cycle of the triple.
        send_triple(8'h04, 8'h05, 8'h02, 0, 1'b1, acc1);
        check("t1_x1", 32'(x1), 32'h04);
        check("t1_x2", 32'(x2), 32'h05);
        check("t1_x3", 32'(x3), 32'h02);
        check("t1_wait_valid", 32'(bus.res_valid), 32'd0);
        check("t1_wait_in_ready", 32'(bus.in_ready), 32'd0);
        wait_valid(at);
        check("t1_latency", 32'(at - acc1), 32'd3);
        wait_drain();

        // 2. Overflow wraps bit-exact, zero operands.
        send_triple(8'h10, 8'h10, 8'h00, 0, 1'b1, acc1);
        send_triple(8'h00, 8'h00, 8'h00, 0, 1'b1, acc1);
        wait_drain();

        // 3. Back-pressure: result held stable, no bytes accepted.
        bus.res_ready = 1'b0;
        send_triple(8'h03, 8'h04, 8'h05, 0, 1'b1, acc1);
        wait_valid(at);
        for (int i = 0; i < 10; i++) begin
            check("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check("bp_res_data", 32'(bus.res_data), 32'h20);
            check("bp_res_tag", 32'(bus.res_tag), 32'd3);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(bus.res_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        wait_drain();

        // 4. Resync drops the partial triple once; tag advances by one only.
        drop_base = drop_cnt;
        push_exp(8'h04, 8'h05, 8'h02);
        send_byte(8'h07, 1'b1, 0, acc1);
        send_byte(8'h03, 1'b0, 0, acc1);
        check("rs_no_drop", 32'(drop_err), 32'd0);
        send_byte(8'h04, 1'b1, 0, acc1);
        check("rs_drop_pulse", 32'(drop_err), 32'd1);
        check("rs_x1_reload", 32'(x1), 32'h04);
        send_byte(8'h05, 1'b0, 0, acc1);
        check("rs_drop_cleared", 32'(drop_err), 32'd0);
        send_byte(8'h02, 1'b0, 0, acc1);
        wait_drain();
        check("rs_drop_count", 32'(drop_cnt - drop_base), 32'd1);

        // 5. Asynchronous reset during WAIT discards everything.
        send_triple(8'h04, 8'h05, 8'h02, 0, 1'b0, acc1);
        #1;
        rst = 1'b1;
        #1;
        check("mr_res_valid", 32'(bus.res_valid), 32'd0);
        check("mr_x1", 32'(x1), 32'd0);
        check("mr_x3", 32'(x3), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_res_tag", 32'(bus.res_tag), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        exp_tag = '0;
        send_triple(8'h01, 8'h01, 8'h01, 0, 1'b1, acc1);
        wait_drain();

        // 6. Tag wrap with back-to-back triples, then with random gaps.
        do_reset();
        acc_prev = 0;
        for (int i = 0; i < 17; i++) begin
            send_triple(8'h01, 8'h02, 8'h03, 0, 1'b1, acc1);
            if (i > 0) check("min_triple_period", 32'(acc1 - acc_prev), 32'd5);
            acc_prev = acc1;
        end
        wait_drain();
        for (int i = 0; i < 17; i++) begin
            send_triple(8'h01, 8'h02, 8'h03, 3, 1'b1, acc1);
        end
        wait_drain();
        check("drop_total", 32'(drop_cnt - drop_base), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
